// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into instruction bits [31:7] for a format code,
// as a 2-stage valid/ready pipeline with range checking and a saturating error counter.
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [24:0]          out_field,
    output logic [24:0]          out_mask,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        OP_I     = 3'd0,
        OP_SHAMT = 3'd1,
        OP_S     = 3'd2,
        OP_U     = 3'd3,
        OP_B     = 3'd4,
        OP_J     = 3'd5,
        OP_BAD6  = 3'd6,
        OP_BAD7  = 3'd7
    } op_e;

    typedef struct packed {
        logic [24:0] field;
        logic [24:0] mask;
    } packed_t;

    // True when imm is representable by the format; upper bits must be a pure sign extension.
    function automatic logic range_ok(input op_e op, input logic [31:0] imm);
        range_ok = 1'b0;
        case (op)
            OP_I, OP_S: range_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
            OP_SHAMT:   range_ok = (imm[31:5] == '0);
            OP_U:       range_ok = (imm[11:0] == '0);
            OP_B:       range_ok = !imm[0] && ((imm[31:12] == '0) || (imm[31:12] == '1));
            OP_J:       range_ok = !imm[0] && ((imm[31:20] == '0) || (imm[31:20] == '1));
            default:    range_ok = 1'b0;
        endcase
    endfunction

    function automatic packed_t pack(input op_e op, input logic [31:0] imm);
        pack = '0;
        case (op)
            OP_I: begin
                pack.field[24:13] = imm[11:0];
                pack.mask         = 25'h1FFE000;
            end
            OP_SHAMT: begin
                pack.field[17:13] = imm[4:0];
                pack.mask         = 25'h003E000;
            end
            OP_S: begin
                pack.field[24:18] = imm[11:5];
                pack.field[4:0]   = imm[4:0];
                pack.mask         = 25'h1FC001F;
            end
            OP_U: begin
                pack.field[24:5]  = imm[31:12];
                pack.mask         = 25'h1FFFFE0;
            end
            OP_B: begin
                pack.field[24]    = imm[12];
                pack.field[0]     = imm[11];
                pack.field[23:18] = imm[10:5];
                pack.field[4:1]   = imm[4:1];
                pack.mask         = 25'h1FC001F;
            end
            OP_J: begin
                pack.field[24]    = imm[20];
                pack.field[12:5]  = imm[19:12];
                pack.field[13]    = imm[11];
                pack.field[23:14] = imm[10:1];
                pack.mask         = 25'h1FFFFE0;
            end
            default: pack = '0;
        endcase
    endfunction

    logic        s1_valid;
    op_e         s1_op;
    logic [31:0] s1_imm;
    logic        s1_err;
    logic        s1_adv;
    logic        in_fire;
    packed_t     s1_packed;

    assign s1_adv    = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign s1_packed = pack(s1_op, s1_imm);

    // NOTE: payload registers carry no reset; the valid flag alone decides whether they matter.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_op  <= op_e'(in_op);
            s1_imm <= in_imm;
            s1_err <= !range_ok(op_e'(in_op), in_imm);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_field <= '0;
            out_mask  <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end

            // A result leaving S2 and a new one arriving in the same cycle overlap with no bubble.
            if (s1_adv) begin
                out_valid <= 1'b1;
                out_field <= s1_packed.field;
                out_mask  <= s1_packed.mask;
                out_err   <= s1_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized-order checks of imm_encoder: packing table, range boundaries,
// handshake ordering under backpressure, error-counter saturation and mid-flight reset.
module tb_imm_encoder;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [24:0]   out_field;
    logic [24:0]   out_mask;
    logic          out_err;
    logic [CW-1:0] err_cnt;

    int n_vec   = 0;
    int n_miss  = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [24:0] field;
        logic        err;
    } vec_t;

    vec_t vecs[18];
    logic [34:0] q[$];

    imm_encoder #(.ERR_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_mask  (out_mask),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] mask_of(input logic [2:0] op);
        case (op)
            3'd0:    mask_of = 25'h1FFE000;
            3'd1:    mask_of = 25'h003E000;
            3'd2:    mask_of = 25'h1FC001F;
            3'd3:    mask_of = 25'h1FFFFE0;
            3'd4:    mask_of = 25'h1FC001F;
            3'd5:    mask_of = 25'h1FFFFE0;
            default: mask_of = 25'h0;
        endcase
    endfunction

    // Decode-stage sign-extender: the inverse the encoder must round-trip through.
    function automatic logic [31:0] sext(input logic [2:0] op, input logic [24:0] f);
        case (op)
            3'd0:    sext = {{20{f[24]}}, f[24:13]};
            3'd1:    sext = {27'b0, f[17:13]};
            3'd2:    sext = {{20{f[24]}}, f[24:18], f[4:0]};
            3'd3:    sext = {f[24:5], 12'b0};
            3'd4:    sext = {{19{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
            3'd5:    sext = {{11{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
            default: sext = 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic run_one(input string tag, input logic [2:0] op, input logic [31:0] imm,
                           input logic [24:0] ef, input logic ee);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_imm    = imm;
        out_ready = 1'b1;
        #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd2);
        check({tag, ".field"}, 32'(out_field), 32'(ef));
        check({tag, ".mask"}, 32'(out_mask), 32'(mask_of(op)));
        check({tag, ".err"}, 32'(out_err), 32'(ee));
        @(posedge clk);
        @(negedge clk);
        if (ee) exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
        check({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_imm    = 32'h0;
        out_ready = 1'b0;

        vecs[0]  = '{3'd0, 32'hFFFFF800, 25'h1000000, 1'b0};
        vecs[1]  = '{3'd0, 32'h00000800, 25'h1000000, 1'b1};
        vecs[2]  = '{3'd0, 32'h000007FF, 25'h0FFE000, 1'b0};
        vecs[3]  = '{3'd1, 32'h0000001F, 25'h003E000, 1'b0};
        vecs[4]  = '{3'd1, 32'h00000020, 25'h0000000, 1'b1};
        vecs[5]  = '{3'd1, 32'hFFFFFFFF, 25'h003E000, 1'b1};
        vecs[6]  = '{3'd2, 32'hFFFFF800, 25'h1000000, 1'b0};
        vecs[7]  = '{3'd2, 32'h000007FF, 25'h0FC001F, 1'b0};
        vecs[8]  = '{3'd3, 32'h12345000, 25'h02468A0, 1'b0};
        vecs[9]  = '{3'd3, 32'h12345001, 25'h02468A0, 1'b1};
        vecs[10] = '{3'd4, 32'h00000FFE, 25'h0FC001F, 1'b0};
        vecs[11] = '{3'd4, 32'h00000003, 25'h0000002, 1'b1};
        vecs[12] = '{3'd4, 32'h00001000, 25'h1000000, 1'b1};
        vecs[13] = '{3'd4, 32'hFFFFF000, 25'h1000000, 1'b0};
        vecs[14] = '{3'd5, 32'hFFFFFFFE, 25'h1FFFFE0, 1'b0};
        vecs[15] = '{3'd5, 32'h000FFFFE, 25'h0FFFFE0, 1'b0};
        vecs[16] = '{3'd5, 32'h00100000, 25'h1000000, 1'b1};
        vecs[17] = '{3'd6, 32'h00000005, 25'h0000000, 1'b1};

        do_reset();
        @(negedge clk);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_field", 32'(out_field), 32'd0);
        check("reset.out_mask", 32'(out_mask), 32'd0);
        check("reset.out_err", 32'(out_err), 32'd0);
        check("reset.err_cnt", 32'(err_cnt), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i])
            run_one($sformatf("dir%0d", i), vecs[i].op, vecs[i].imm, vecs[i].field, vecs[i].err);

        // Back-to-back legal traffic with random backpressure; checked in order via round trip.
        do_reset();
        begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            logic fire;
            while (got < 16 && cyc < 600) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                if (!in_valid && sent < 16) begin
                    int v;
                    in_op = 3'($urandom_range(0, 5));
                    case (in_op)
                        3'd0, 3'd2: v = int'($urandom_range(0, 4095)) - 2048;
                        3'd1:       v = int'($urandom_range(0, 31));
                        3'd3:       v = int'($urandom() & 32'hFFFFF000);
                        3'd4:       v = (int'($urandom_range(0, 8191)) - 4096) & ~1;
                        default:    v = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
                    endcase
                    in_imm   = 32'(v);
                    in_valid = 1'b1;
                end
                #1;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("rand.unexpected_result", 32'(out_valid), 32'd0);
                    end else begin
                        logic [34:0] e;
                        e = q.pop_front();
                        check($sformatf("rand%0d.roundtrip", got), sext(e[34:32], out_field), e[31:0]);
                        check($sformatf("rand%0d.mask", got), 32'(out_mask), 32'(mask_of(e[34:32])));
                        check($sformatf("rand%0d.err", got), 32'(out_err), 32'd0);
                    end
                    got++;
                end
                fire = in_valid && in_ready;
                if (fire) begin
                    q.push_back({in_op, in_imm});
                    sent++;
                end
                @(posedge clk);
                #1 if (fire) in_valid = 1'b0;
                cyc++;
            end
            check("rand.results_received", 32'(got), 32'd16);
            check("rand.err_cnt", 32'(err_cnt), 32'd0);
        end

        // Saturation of the 2-bit error counter.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_one($sformatf("sat%0d", i), 3'd7, 32'(i), 25'h0, 1'b1);
        check("sat.final", 32'(err_cnt), 32'd3);

        // Two erroring results in flight with the output stalled, then reset.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd7;
        in_imm    = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("flush.pre_out_valid", 32'(out_valid), 32'd1);
        check("flush.pre_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.err_cnt", 32'(err_cnt), 32'd0);
        check("flush.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("flush.post_out_valid", 32'(out_valid), 32'd0);
        check("flush.post_err_cnt", 32'(err_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
